// File: rtl/router_pkg.sv
// Shared router definitions: packet FSM states, header field layout, helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PLD,
    PAR,
    DROP
  } state_t;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Header byte = {len[5:0], addr[1:0]}
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;
  localparam int LEN_W        = 6;

  function automatic logic [1:0] hdr_addr(input logic [7:0] h);
    return h[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] h);
    return h[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/router_ingress_arb_if.sv
// Ingress bundle: N_SRC source byte lanes with req/ready, router data/pkt_valid/busy, status.
// Latency: n/a (wires only).
// Backpressure: busy from the router, src_ready back to the sources.
// slave modport = arbiter side, master modport = sources/router side.
interface router_ingress_arb_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]   src_req;
  logic [8*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]   src_ready;
  logic               busy;
  logic [7:0]         rtr_data;
  logic               rtr_pkt_valid;
  logic [N_SRC-1:0]   grant;
  logic               addr_err;
  logic               proto_err;

  modport slave (
    input  src_req, src_data, busy,
    output src_ready, rtr_data, rtr_pkt_valid, grant, addr_err, proto_err
  );

  modport master (
    output src_req, src_data, busy,
    input  src_ready, rtr_data, rtr_pkt_valid, grant, addr_err, proto_err
  );
endinterface

// File: rtl/router_rr_pick.sv
// Round-robin picker: first requester strictly after ptr (wrapping); ports req, ptr -> gnt (one-hot), idx, vld.
// Latency: combinational.
// Backpressure: none; vld low when no request.
module router_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    // k = N wraps back to ptr itself, so the last owner gets lowest priority.
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!vld && req[cand]) begin
        vld       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/router_ingress_arb.sv
// Packet-level round-robin arbiter muxing N_SRC sources onto the router input; drops addr-3 packets.
// Latency: grant 1 cycle after request; data path source->router combinational; 1 idle cycle between packets.
// Backpressure: router busy gates src_ready of the owner (except while dropping); ports clock, reset, bus.
module router_ingress_arb
  import router_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  router_ingress_arb_if.slave  bus
);
  localparam int IW = $clog2(N_SRC);

  state_t             state, state_nxt;
  logic [N_SRC-1:0]   grant_q, grant_nxt;
  logic [IW-1:0]      gidx_q, gidx_nxt;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
  logic [6:0]         cnt, cnt_nxt;

  logic [N_SRC-1:0]   pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;

  logic [7:0]         lane;
  logic               req_g;
  logic               ready_g;
  logic               pv;
  logic [7:0]         rd;
  logic               aerr;
  logic               perr;

  router_rr_pick #(.N(N_SRC), .IW(IW)) u_pick (
    .req (bus.src_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Owner lane: byte and request of the granted source.
  always_comb begin
    lane  = '0;
    req_g = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gidx_q == IW'(i)) begin
        lane  = bus.src_data[8*i +: 8];
        req_g = bus.src_req[i];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_q;
    gidx_nxt   = gidx_q;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    ready_g    = 1'b0;
    pv         = 1'b0;
    rd         = '0;
    aerr       = 1'b0;
    perr       = 1'b0;

    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick_gnt;
          gidx_nxt  = pick_idx;
          state_nxt = HDR;
        end
      end
      HDR: begin
        if (hdr_addr(lane) == ADDR_INVALID) begin
          // Unrouteable: swallow header, payload and parity without stalling on busy.
          ready_g = 1'b1;
          if (req_g) begin
            aerr      = 1'b1;
            cnt_nxt   = {1'b0, hdr_len(lane)} + 7'd1;
            state_nxt = DROP;
          end
        end else begin
          pv      = 1'b1;
          rd      = lane;
          ready_g = ~bus.busy;
          if (req_g && ready_g) begin
            cnt_nxt   = {1'b0, hdr_len(lane)};
            state_nxt = (hdr_len(lane) == '0) ? PAR : PLD;
          end
        end
      end
      PLD: begin
        pv      = 1'b1;
        rd      = lane;
        ready_g = ~bus.busy;
        if (req_g && ready_g) begin
          cnt_nxt = cnt - 7'd1;
          if (cnt == 7'd1) state_nxt = PAR;
        end
      end
      PAR: begin
        rd      = lane;
        ready_g = ~bus.busy;
        if (req_g && ready_g) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = gidx_q;
        end
      end
      DROP: begin
        ready_g = 1'b1;
        if (req_g) begin
          cnt_nxt = cnt - 7'd1;
          if (cnt == 7'd1) begin
            state_nxt  = IDLE;
            grant_nxt  = '0;
            rr_ptr_nxt = gidx_q;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase

    // Owner abandoned its packet: release the port; router parity catches the truncation.
    if (state != IDLE && !req_g) begin
      perr       = 1'b1;
      state_nxt  = IDLE;
      grant_nxt  = '0;
      rr_ptr_nxt = gidx_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_ptr  <= IW'(N_SRC - 1);
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      gidx_q  <= gidx_nxt;
      rr_ptr  <= rr_ptr_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign bus.src_ready     = ready_g ? grant_q : '0;
  assign bus.rtr_data      = rd;
  assign bus.rtr_pkt_valid = pv;
  assign bus.grant         = grant_q;
  assign bus.addr_err      = aerr;
  assign bus.proto_err     = perr;

endmodule

// File: tb/tb_router_ingress_arb.sv
// Directed bench for router_ingress_arb: cycle-by-cycle vector table plus a round-robin sequence.
// Latency: expectations assume grant at t+1 and combinational data path.
// Backpressure: busy rows expect src_ready low with rtr_data following the held lane.
module tb_router_ingress_arb;
  logic clock;
  logic reset;

  router_ingress_arb_if #(.N_SRC(4)) bus ();

  router_ingress_arb #(.N_SRC(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        busy;
    logic [3:0]  g;
    logic [3:0]  rdy;
    logic        pv;
    logic [7:0]  rd;
    logic        ae;
    logic        pe;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic add(input logic rst, input logic [3:0] req, input logic [31:0] data,
                     input logic busy, input logic [3:0] g, input logic [3:0] rdy,
                     input logic pv, input logic [7:0] rd, input logic ae, input logic pe);
    vec_t v;
    v.rst = rst; v.req = req; v.data = data; v.busy = busy;
    v.g = g; v.rdy = rdy; v.pv = pv; v.rd = rd; v.ae = ae; v.pe = pe;
    vecs.push_back(v);
  endtask

  task automatic check_row(input int n, input vec_t v);
    logic [17:0] act, exp;
    act = {bus.grant, bus.src_ready, bus.rtr_pkt_valid, bus.rtr_data, bus.addr_err, bus.proto_err};
    exp = {v.g, v.rdy, v.pv, v.rd, v.ae, v.pe};
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL row%0d: got grant=%b ready=%b pv=%b data=%h aerr=%b perr=%b, want grant=%b ready=%b pv=%b data=%h aerr=%b perr=%b",
               n, bus.grant, bus.src_ready, bus.rtr_pkt_valid, bus.rtr_data, bus.addr_err, bus.proto_err,
               v.g, v.rdy, v.pv, v.rd, v.ae, v.pe);
    end
  endtask

  initial begin
    logic [3:0] exp_g;

    reset        = 1'b1;
    bus.src_req  = '0;
    bus.src_data = '0;
    bus.busy     = 1'b0;
    repeat (2) begin
      @(negedge clock);
      bus.src_req  = 4'($urandom);
      bus.src_data = $urandom;
      bus.busy     = 1'($urandom);
    end

    // Reset held with arbitrary inputs: everything quiet.
    add(1, 4'hF, 32'hDEADBEEF, 1, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    // Source 0 wins first with all requesting; header 0D (addr1 len3), 3 payload, parity.
    add(0, 4'hF, 32'h3121110D, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'h1, 32'h0000000D, 0, 4'h1, 4'h1, 1, 8'h0D, 0, 0);
    add(0, 4'h1, 32'h000000A1, 0, 4'h1, 4'h1, 1, 8'hA1, 0, 0);
    add(0, 4'h1, 32'h000000A2, 0, 4'h1, 4'h1, 1, 8'hA2, 0, 0);
    add(0, 4'h1, 32'h000000A3, 0, 4'h1, 4'h1, 1, 8'hA3, 0, 0);
    add(0, 4'h1, 32'h0000005A, 0, 4'h1, 4'h1, 0, 8'h5A, 0, 0);
    add(0, 4'h0, 32'h00000000, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    // Source 1, len 0: header then parity.
    add(0, 4'h2, 32'h00000100, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'h2, 32'h00000100, 0, 4'h2, 4'h2, 1, 8'h01, 0, 0);
    add(0, 4'h2, 32'h0000C300, 0, 4'h2, 4'h2, 0, 8'hC3, 0, 0);
    add(0, 4'h0, 32'h00000000, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    // Source 2, header 07 (addr3 len1): dropped even while busy, 2 more bytes swallowed.
    add(0, 4'h4, 32'h00070000, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'h4, 32'h00070000, 1, 4'h4, 4'h4, 0, 8'h00, 1, 0);
    add(0, 4'h4, 32'h00110000, 0, 4'h4, 4'h4, 0, 8'h00, 0, 0);
    add(0, 4'h4, 32'h00220000, 0, 4'h4, 4'h4, 0, 8'h00, 0, 0);
    add(0, 4'h0, 32'h00000000, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    // Source 3, len 3, busy for 5 cycles before the last payload byte.
    add(0, 4'h8, 32'h0D000000, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'h8, 32'h0D000000, 0, 4'h8, 4'h8, 1, 8'h0D, 0, 0);
    add(0, 4'h8, 32'hB1000000, 0, 4'h8, 4'h8, 1, 8'hB1, 0, 0);
    add(0, 4'h8, 32'hB2000000, 0, 4'h8, 4'h8, 1, 8'hB2, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 4'h8, 32'hB3000000, 1, 4'h8, 4'h0, 1, 8'hB3, 0, 0);
    add(0, 4'h8, 32'hB3000000, 0, 4'h8, 4'h8, 1, 8'hB3, 0, 0);
    add(0, 4'h8, 32'h77000000, 0, 4'h8, 4'h8, 0, 8'h77, 0, 0);
    add(0, 4'h0, 32'h00000000, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    // Source 0 drops its request mid-payload.
    add(0, 4'h1, 32'h0000000D, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'h1, 32'h0000000D, 0, 4'h1, 4'h1, 1, 8'h0D, 0, 0);
    add(0, 4'h1, 32'h000000A1, 0, 4'h1, 4'h1, 1, 8'hA1, 0, 0);
    add(0, 4'h0, 32'h000000A2, 0, 4'h1, 4'h1, 1, 8'hA2, 0, 1);
    add(0, 4'h0, 32'h00000000, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    // Reset in the middle of a packet from source 1.
    add(0, 4'h2, 32'h00000D00, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'h2, 32'h00000D00, 0, 4'h2, 4'h2, 1, 8'h0D, 0, 0);
    add(1, 4'h2, 32'h0000A100, 0, 4'h2, 4'h2, 1, 8'hA1, 0, 0);
    add(0, 4'h2, 32'h00000D00, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'h2, 32'h00000D00, 0, 4'h2, 4'h2, 1, 8'h0D, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clock);
      reset        = vecs[i].rst;
      bus.src_req  = vecs[i].req;
      bus.src_data = vecs[i].data;
      bus.busy     = vecs[i].busy;
      #1;
      check_row(i, vecs[i]);
    end

    // Round robin: sources 0,1,2 stream len-1 packets (every byte 05 = addr1 len1).
    @(negedge clock);
    reset       = 1'b1;
    bus.src_req = '0;
    @(negedge clock);
    reset        = 1'b0;
    bus.src_req  = 4'b0111;
    bus.src_data = 32'h00050505;
    bus.busy     = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      // 4-cycle period: idle, header, payload, parity; owner cycles 0,1,2.
      exp_g = (c % 4 == 0) ? 4'h0 : 4'(1 << ((c / 4) % 3));
      tests++;
      if (bus.grant !== exp_g) begin
        failed++;
        $display("FAIL rr_cycle%0d: got grant=%b want grant=%b", c, bus.grant, exp_g);
      end
      @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/router_ingress_arb.md
# router_ingress_arb

Packet-level ingress arbiter that shares the router's single input port between `N_SRC` packet sources. It grants one source at a time, round-robin, and holds the grant for a whole packet (header, payload, parity). It muxes the granted stream onto the router's `data_in`/`pkt_valid` and applies the router's `busy` back-pressure to that source. Headers with the unrouteable address `2'b11` are consumed and discarded without reaching the router.

## Interface
- `N_SRC`, 4: number of requesting sources, legal range 2..4.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `src_req`  in  N_SRC  source i has a valid byte on its `src_data` lane.
- `src_data`  in  8*N_SRC  byte lane i = bits [8i+7:8i].
- `src_ready`  out  N_SRC  byte i is taken this cycle when `src_req[i] & src_ready[i]`.
- `busy`  in  1  router busy; no byte is taken while high.
- `rtr_data`  out  8  to router `data_in`.
- `rtr_pkt_valid`  out  1  to router `pkt_valid`.
- `grant`  out  N_SRC  one-hot owner of the port; 0 when idle.
- `addr_err`  out  1  one-cycle pulse when a header with addr 3 is dropped.
- `proto_err`  out  1  one-cycle pulse when the owner drops `src_req` mid-packet.

## Operation
- Packet format: header byte = {len[5:0], addr[1:0]}, then `len` payload bytes, then 1 parity byte. `len` = 0 is legal and means header then parity.
- A transfer on the owner lane `g` is `src_req[g] & src_ready[g]`. At most one `src_ready` bit is high, always `grant`'s bit.
- States:
  - IDLE
    - `rtr_pkt_valid`=0, `rtr_data`=0, `src_ready`=0.
    - If any `src_req` is high, pick the first requester after `rr_ptr` (wrapping), register `grant`, go to HDR.
  - HDR
    - addr != 3: `rtr_data`=`src_data[g]`, `rtr_pkt_valid`=1, `src_ready[g]`=~busy. On transfer, load `cnt`=len and go to PLD (or PAR if len==0).
    - addr == 3: `rtr_pkt_valid`=0, `rtr_data`=0, `src_ready[g]`=1 regardless of `busy`. On transfer, pulse `addr_err`, load `cnt`=len+1 (7 bits), go to DROP.
  - PLD
    - `rtr_pkt_valid`=1, `rtr_data`=`src_data[g]`, `src_ready[g]`=~busy.
    - Each transfer decrements `cnt`. The transfer taken with `cnt`==1 moves to PAR.
  - PAR
    - `rtr_pkt_valid`=0, `rtr_data`=`src_data[g]`, `src_ready[g]`=~busy.
    - On transfer, set `rr_ptr`=g, clear `grant`, go to IDLE.
  - DROP
    - `rtr_pkt_valid`=0, `rtr_data`=0, `src_ready[g]`=1.
    - Each transfer decrements `cnt`. At `cnt`==1 the transfer sets `rr_ptr`=g and goes to IDLE.
- `src_req[g]` low in HDR/PLD/PAR/DROP:
  - pulse `proto_err` in that cycle, set `rr_ptr`=g, go to IDLE;
  - the truncated packet is left to the router's parity check.
- The grant never changes mid-packet, whatever other requests do.
- Any `src_req` bit that is not `grant`'s bit is ignored outside IDLE.

## Timing
- Reset (sync, priority over everything):
  - state=IDLE, `grant`=0, `rr_ptr`=N_SRC-1 (source 0 wins first), `cnt`=0;
  - all outputs 0 in the following cycle.
  - Reset mid-packet abandons the packet with no error pulse.
- `grant`, state, `cnt` and `rr_ptr` are registered.
- `rtr_data`, `rtr_pkt_valid` and `src_ready` are combinational from the state, `grant` and the owner lane, so zero latency from source to router.
- Arbitration latency: `src_req` high in IDLE at cycle t gives `grant` and the header on `rtr_data` at t+1.
- Back-to-back packets: parity transfer at t → IDLE at t+1 → next header at t+2. There is one mandatory idle cycle between packets.
- `busy` high freezes `cnt` and holds `src_ready`=0; `rtr_data` follows the (held) source lane.
- Best-case packet cost is len+3 cycles including the idle cycle.

## Structure
- Shared package `router_pkg` holds:
  - the state enum {IDLE, HDR, PLD, PAR, DROP};
  - `ADDR_INVALID`=2'b11;
  - header field positions `HDR_ADDR`=[1:0] and `HDR_LEN`=[7:2];
  - `LEN_W`=6.
- Sub-module `router_rr_pick`: combinational round-robin picker with inputs (req, ptr) and outputs one-hot grant plus index. Reused by later egress schedulers.

## Test plan
- Reset with random inputs → all outputs 0. With all `src_req` high, the first grant is 4'b0001.
- Source 0 sends header 8'h0D (addr 1, len 3), payload 8'hA1/A2/A3, parity 8'hXX, `busy`=0 → `rtr_pkt_valid` high for 4 bytes, low on the parity byte; `grant` returns to 0 after parity.
- Header 8'h01 (addr 1, len 0) → header then parity only, `rtr_pkt_valid` high for exactly 1 cycle.
- Sources 0, 1, 2 requesting continuously with len-1 packets → grant order 0,1,2,0, with one idle cycle between packets.
- `busy` held high for 5 cycles after payload byte 2 of 3 → `src_ready` low for 5 cycles, `cnt` unchanged, packet completes normally.
- Error and abort cases:
  - Header 8'h07 (addr 3, len 1) → `addr_err` pulses once, 2 more bytes consumed, `rtr_pkt_valid` stays 0.
  - `src_req[g]` dropped mid-payload → `proto_err` pulse, IDLE on the next cycle.
  - `reset` mid-packet → IDLE, `grant`=0.
